// File: rtl/rv_mem_resp_if.sv
// rtl/rv_mem_resp_if.sv - request/response bus between a CPU and rv_mem_resp
//
// Signals (master = CPU side, slave = responder side):
//   req_valid  M->S  1   CPU presents a memory request
//   req_we     M->S  1   1 = write, 0 = read
//   req_addr   M->S  32  byte address
//   req_wdata  M->S  32  write data
//   req_ready  S->M  1   responder can accept a request this cycle
//   rsp_valid  S->M  1   response available
//   rsp_ready  M->S  1   CPU consumes the response this cycle
//   rsp_rdata  S->M  32  read data, 0 for writes and errors
//   rsp_err    S->M  1   request was misaligned or out of range
//   busy       S->M  1   a request is in flight
interface rv_mem_resp_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/rv_mem_resp.sv
// rtl/rv_mem_resp.sv - fixed-latency word RAM responder with error reporting
//
// Parameters:
//   DEPTH    number of 32-bit RAM words (power of two, 16..4096)
//   LATENCY  wait cycles between acceptance and the RAM access (0..15)
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of rv_mem_resp_if (request/response handshake, busy)
module rv_mem_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          rst,
  rv_mem_resp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_rsp_valid;

  // RAM is deliberately left out of reset: contents survive rst.
  logic [31:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_access;
  logic          w_consume;
  logic          w_acc_we;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic          w_acc_err;
  logic [AW-1:0] w_acc_idx;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_consume = (r_state == S_RESP) && bus.rsp_ready;

  // With LATENCY=0 the access happens on the acceptance edge, so it must
  // use the live request inputs; otherwise the latched copy is used.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      w_acc_we    = bus.req_we;
      w_acc_addr  = bus.req_addr;
      w_acc_wdata = bus.req_wdata;
    end
  end

  assign w_access  = (LATENCY == 0) ? w_accept
                                    : ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_acc_err = (w_acc_addr[1:0] != 2'b00) ||
                     (w_acc_addr[31:2] >= 30'(DEPTH));
  // Low index bits may alias for out-of-range addresses; w_acc_err masks that.
  assign w_acc_idx = w_acc_addr[AW+1:2];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= LAT_M1;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_err       <= w_acc_err;
        r_rdata     <= (w_acc_we || w_acc_err) ? 32'd0 : r_mem[w_acc_idx];
      end else if (w_consume) begin
        r_rsp_valid <= 1'b0;
        r_err       <= 1'b0;
        r_rdata     <= 32'd0;
      end
    end
  end

  // rst gates the write so a reset landing on the access edge drops it.
  always_ff @(posedge clk) begin
    if (w_access && w_acc_we && !w_acc_err && !rst) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
